instr_fetch: RTL and testbench

- Fetch stage directly upstream of the control decoder. Holds the PC and requests instructions from a variable-latency instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register and presents the decoded fields (opcode, funct, rs, rt, rd, imm, target) to control and the datapath.
- When the downstream side says advance, computes the next PC from control's Jump/JumpSel/Branch and the ALU zero flag.

---
 rtl/instr_fetch.sv | 158 +++++++++++++++
 tb/tb_instr_fetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory handshake, holds the word for decode.
// Optional IFETCH_PERF_CNT_EN adds retired/stall performance counters.
module instr_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        advance,
    input  logic        jump,
    input  logic        jump_sel,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic [31:0] jr_addr,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] target,
    output logic [31:0] pc,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0] retired_count,
    output logic [31:0] stall_count,
`endif
    output logic [31:0] pc_plus4,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_RST,
        S_FETCH,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam bit          TIMEOUT_EN   = (IMEM_TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(IMEM_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic        valid_reg, valid_next;
    logic        fault_reg, fault_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [31:0] next_pc;
    logic [31:0] branch_off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_RST;
            pc_reg    <= RESET_PC;
            instr_reg <= 32'h0;
            valid_reg <= 1'b0;
            fault_reg <= 1'b0;
            cnt_reg   <= 32'h0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            fault_reg <= fault_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Branch offset is word-scaled and sign-extended; all sums wrap mod 2^32.
    assign branch_off = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};

    always_comb begin
        if (jump && jump_sel)
            next_pc = jr_addr;
        else if (jump)
            next_pc = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
        else if (branch && !alu_zero)
            next_pc = pc_plus4 + branch_off;
        else
            next_pc = pc_plus4;
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        valid_next = valid_reg;
        fault_next = fault_reg;
        cnt_next   = cnt_reg;
        imem_req   = 1'b0;
        case (state_reg)
            S_RST: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                cnt_next = cnt_reg + 32'd1;
                // Ack takes precedence over a timeout landing on the same edge.
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    valid_next = 1'b1;
                    cnt_next   = 32'h0;
                    state_next = S_HOLD;
                end else if (TIMEOUT_EN && (cnt_reg == TIMEOUT_LAST)) begin
                    fault_next = 1'b1;
                    state_next = S_FAULT;
                end
            end
            S_HOLD: begin
                if (advance) begin
                    pc_next    = next_pc;
                    valid_next = 1'b0;
                    state_next = S_FETCH;
                end
            end
            S_FAULT: begin
                valid_next = 1'b0;
            end
            default: begin
                state_next = S_RST;
            end
        endcase
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count <= 32'h0;
            stall_count   <= 32'h0;
        end else begin
            if (state_reg == S_HOLD && advance)
                retired_count <= retired_count + 32'd1;
            if (state_reg == S_FETCH && !imem_ack)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign pc_plus4    = pc_reg + 32'd4;
    assign instr       = instr_reg;
    assign instr_valid = valid_reg;
    assign fault       = fault_reg;
    assign opcode      = instr_reg[31:26];
    assign rs          = instr_reg[25:21];
    assign rt          = instr_reg[20:16];
    assign rd          = instr_reg[15:11];
    assign funct       = instr_reg[5:0];
    assign imm         = instr_reg[15:0];
    assign target      = instr_reg[25:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table of fetch/advance vectors plus reset, timeout and counter sequences.
module tb_instr_fetch;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        advance, jump, jump_sel, branch, alu_zero;
    logic [31:0] jr_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] pc, pc_plus4;
    logic        fault;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] retired_count, stall_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC), .IMEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .advance(advance), .jump(jump), .jump_sel(jump_sel),
        .branch(branch), .alu_zero(alu_zero), .jr_addr(jr_addr),
        .instr_valid(instr_valid), .instr(instr),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
        .imm(imm), .target(target), .pc(pc),
`ifdef IFETCH_PERF_CNT_EN
        .retired_count(retired_count), .stall_count(stall_count),
`endif
        .pc_plus4(pc_plus4), .fault(fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        jump, jump_sel, branch, alu_zero;
        logic [31:0] jr_addr;
        logic [31:0] next_pc;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge in FETCH; returns at the negedge after the ack edge (HOLD).
    task automatic fetch(input logic [31:0] data, input int waits);
        for (int w = 0; w < waits; w++) begin
            advance  = 1'b1;
            jump     = 1'b1;
            jump_sel = 1'b1;
            jr_addr  = 32'hDEAD_BEE0;
            imem_ack = 1'b0;
            @(negedge clk);
            check("fetch_wait_req", {31'b0, imem_req}, 32'd1);
        end
        advance    = 1'b0;
        jump       = 1'b0;
        jump_sel   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h1357_9BDF;
    endtask

    task automatic do_advance(input logic j, input logic js, input logic b, input logic z,
                              input logic [31:0] jr);
        jump = j; jump_sel = js; branch = b; alu_zero = z; jr_addr = jr;
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        jump = 1'b1; jump_sel = 1'b1; branch = 1'b1; alu_zero = 1'b0; jr_addr = 32'hBAD0_0000;
    endtask

    initial begin
        vecs[0]  = '{32'h0040_0000, 32'h8C48_0004, 0, 0, 0, 0, 32'h0,          32'h0040_0004};
        vecs[1]  = '{32'h0040_0004, 32'h03E0_0008, 1, 1, 0, 0, 32'h0000_0010, 32'h0000_0010};
        vecs[2]  = '{32'h0000_0010, 32'h0800_0040, 1, 0, 0, 0, 32'h0,          32'h0000_0100};
        vecs[3]  = '{32'h0000_0100, 32'h0800_0040, 1, 1, 0, 0, 32'h0000_0010, 32'h0000_0010};
        vecs[4]  = '{32'h0000_0010, 32'h0800_0040, 1, 1, 0, 0, 32'h0000_0200, 32'h0000_0200};
        vecs[5]  = '{32'h0000_0200, 32'h0000_0000, 1, 1, 0, 0, 32'h0000_0020, 32'h0000_0020};
        vecs[6]  = '{32'h0000_0020, 32'h1485_FFFE, 0, 0, 1, 0, 32'h0,          32'h0000_001C};
        vecs[7]  = '{32'h0000_001C, 32'h0000_0000, 1, 1, 0, 0, 32'h0000_0020, 32'h0000_0020};
        vecs[8]  = '{32'h0000_0020, 32'h1485_FFFE, 0, 0, 1, 1, 32'h0,          32'h0000_0024};
        vecs[9]  = '{32'h0000_0024, 32'h0000_0000, 1, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[10] = '{32'hFFFF_FFFC, 32'h1485_FFFE, 0, 0, 0, 0, 32'h0,          32'h0000_0000};
        vecs[11] = '{32'h0000_0000, 32'h1485_FFFE, 0, 0, 1, 0, 32'h0,          32'hFFFF_FFFC};
        vecs[12] = '{32'hFFFF_FFFC, 32'h0000_0000, 1, 1, 0, 0, 32'hF000_0010, 32'hF000_0010};
        vecs[13] = '{32'hF000_0010, 32'h0800_0040, 1, 0, 0, 0, 32'h0,          32'hF000_0100};
        vecs[14] = '{32'hF000_0100, 32'h1485_FFFE, 1, 0, 1, 0, 32'h0,          32'hF217_FFF8};
        vecs[15] = '{32'hF217_FFF8, 32'h0000_0000, 1, 1, 1, 0, 32'h0000_0400, 32'h0000_0400};

        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; advance = 1'b0;
        jump = 1'b0; jump_sel = 1'b0; branch = 1'b0; alu_zero = 1'b0; jr_addr = 32'h0;

        @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_pc", pc, RPC);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        check("rst_retired", retired_count, 32'h0);
        check("rst_stall", stall_count, 32'h0);
`endif
        reset = 1'b0;
        check("rst_cycle_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        check("first_fetch_req", {31'b0, imem_req}, 32'd1);
        check("first_fetch_addr", imem_addr, RPC);

        for (int i = 0; i < 16; i++) begin
            fetch(vecs[i].rdata, i % 3);
            check("hold_valid", {31'b0, instr_valid}, 32'd1);
            check("hold_req", {31'b0, imem_req}, 32'd0);
            check("hold_pc", imem_addr, vecs[i].pc);
            check("hold_instr", instr, vecs[i].rdata);
            if (i == 0) begin
                check("opcode", {26'b0, opcode}, 32'h23);
                check("rs", {27'b0, rs}, 32'd2);
                check("rt", {27'b0, rt}, 32'd8);
                check("rd", {27'b0, rd}, 32'd0);
                check("funct", {26'b0, funct}, 32'd4);
                check("imm", {16'b0, imm}, 32'h0004);
                check("target", {6'b0, target}, 32'h0048_0004);
                check("pc_plus4", pc_plus4, 32'h0040_0004);
            end
            imem_ack = 1'b1;
            imem_rdata = ~vecs[i].rdata;
            @(negedge clk);
            imem_ack = 1'b0;
            check("late_ack_instr", instr, vecs[i].rdata);
            check("late_ack_valid", {31'b0, instr_valid}, 32'd1);
            do_advance(vecs[i].jump, vecs[i].jump_sel, vecs[i].branch, vecs[i].alu_zero, vecs[i].jr_addr);
            check("next_addr", imem_addr, vecs[i].next_pc);
            check("adv_valid", {31'b0, instr_valid}, 32'd0);
            check("adv_req", {31'b0, imem_req}, 32'd1);
            $display("vec %0d: pc=%h instr=%h -> next=%h (expect %h)",
                     i, vecs[i].pc, vecs[i].rdata, imem_addr, vecs[i].next_pc);
        end

        // Timeout: 15 wait cycles still fetching, 16th edge faults.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("to_wait_fault", {31'b0, fault}, 32'd0);
            check("to_wait_req", {31'b0, imem_req}, 32'd1);
        end
        @(negedge clk);
        check("to_fault", {31'b0, fault}, 32'd1);
        check("to_req", {31'b0, imem_req}, 32'd0);
        advance = 1'b1; imem_ack = 1'b1; jump = 1'b1; jump_sel = 1'b1; jr_addr = 32'h0000_0FF0;
        repeat (3) @(negedge clk);
        advance = 1'b0; imem_ack = 1'b0;
        check("fault_sticky", {31'b0, fault}, 32'd1);
        check("fault_pc_frozen", pc, 32'h0000_0400);
        check("fault_valid", {31'b0, instr_valid}, 32'd0);
        check("fault_req", {31'b0, imem_req}, 32'd0);
        $display("timeout: fault=%0d pc=%h", fault, pc);
        reset = 1'b1;
        #1;
        check("fault_cleared", {31'b0, fault}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("resume_req", {31'b0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, RPC);

        // Move away from RESET_PC, then reset during a delayed fetch.
        fetch(32'h0000_0000, 0);
        do_advance(1, 1, 0, 0, 32'h0000_0800);
        check("pre_midrst_addr", imem_addr, 32'h0000_0800);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_req", {31'b0, imem_req}, 32'd0);
        check("midrst_pc", pc, RPC);
        check("midrst_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_ack = 1'b0;
        check("rst_ack_ignored_instr", instr, 32'h0);
        check("rst_ack_ignored_valid", {31'b0, instr_valid}, 32'd0);
        check("after_midrst_req", {31'b0, imem_req}, 32'd1);
        $display("mid-fetch reset: pc=%h req=%0d", pc, imem_req);

`ifdef IFETCH_PERF_CNT_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            fetch(32'h0000_0000, 2);
            do_advance(0, 0, 0, 0, 32'h0);
        end
        check("retired_count", retired_count, 32'd5);
        check("stall_count", stall_count, 32'd10);
        check("perf_pc", pc, RPC + 32'd20);
        $display("perf: retired=%0d stall=%0d", retired_count, stall_count);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
